// File: rtl/pong_ball_ctrl_if.sv
// Bundle between the pong frame/paddle stages and the ball controller.
// The master drives frame timing, pixel position, paddle and serve; the slave returns ball state.
interface pong_ball_ctrl_if;
    logic        frame_end_i;
    logic [10:0] hcount_i;
    logic [10:0] vcount_i;
    logic [10:0] pad_y_i;
    logic        serve_i;
    logic [10:0] ball_x_o;
    logic [10:0] ball_y_o;
    logic        ball_on_o;
    logic        hit_o;
    logic        miss_o;
    logic        playing_o;

    modport master (
        output frame_end_i, hcount_i, vcount_i, pad_y_i, serve_i,
        input  ball_x_o, ball_y_o, ball_on_o, hit_o, miss_o, playing_o
    );

    modport slave (
        input  frame_end_i, hcount_i, vcount_i, pad_y_i, serve_i,
        output ball_x_o, ball_y_o, ball_on_o, hit_o, miss_o, playing_o
    );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Ball motion and serve/miss sequencing for pong; steps once per frame_end and
// produces a one-cycle-latency ball_on overlay from the running pixel counters.
module pong_ball_ctrl #(
    parameter int HMAX        = 640,
    parameter int VMAX        = 480,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int PAD_X       = 600,
    parameter int PAD_H       = 72,
    parameter int SERVE_DELAY = 60
) (
    input logic             clk,
    input logic             reset,
    pong_ball_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, MISS} state_t;

    localparam int              CW       = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [10:0]     CENTER_X = 11'((HMAX - BALL_SIZE) / 2);
    localparam logic [10:0]     CENTER_Y = 11'((VMAX - BALL_SIZE) / 2);
    localparam logic [10:0]     STEP     = 11'(BALL_V);
    localparam logic [10:0]     X_PAD    = 11'(PAD_X - BALL_SIZE);
    localparam logic [10:0]     Y_BOTTOM = 11'(VMAX - BALL_SIZE);
    localparam logic [11:0]     SIZE12   = 12'(BALL_SIZE);
    localparam logic [11:0]     STEP12   = 12'(BALL_V);
    localparam logic [11:0]     HMAX12   = 12'(HMAX);
    localparam logic [11:0]     VMAX12   = 12'(VMAX);
    localparam logic [11:0]     PADX12   = 12'(PAD_X);
    localparam logic [11:0]     PADH12   = 12'(PAD_H);

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic          dx_right_q, dx_right_d, dy_down_q, dy_down_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d, miss_q, miss_d;
    logic          on_q, on_d, playing_q, playing_d;

    logic [11:0] bx, by, pady12, hc12, vc12;
    logic        pad_overlap;

    assign bx          = {1'b0, x_q};
    assign by          = {1'b0, y_q};
    assign pady12      = {1'b0, bus.pad_y_i};
    assign hc12        = {1'b0, bus.hcount_i};
    assign vc12        = {1'b0, bus.vcount_i};
    assign pad_overlap = (by + SIZE12 > pady12) && (by < pady12 + PADH12);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= CENTER_X;
            y_q        <= CENTER_Y;
            dx_right_q <= 1'b1;
            dy_down_q  <= 1'b1;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            on_q       <= 1'b0;
            playing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dx_right_q <= dx_right_d;
            dy_down_q  <= dy_down_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            on_q       <= on_d;
            playing_q  <= playing_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_right_d = dx_right_q;
        dy_down_d  = dy_down_q;
        cnt_d      = cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        case (state_q)
            IDLE: begin
                x_d = CENTER_X;
                y_d = CENTER_Y;
                if (bus.serve_i) state_d = PLAY;
            end
            PLAY: begin
                if (bus.frame_end_i) begin
                    if (!dy_down_q && by < STEP12) begin
                        y_d       = '0;
                        dy_down_d = 1'b1;
                    end else if (dy_down_q && (by + SIZE12 + STEP12 > VMAX12)) begin
                        y_d       = Y_BOTTOM;
                        dy_down_d = 1'b0;
                    end else begin
                        y_d = dy_down_q ? y_q + STEP : y_q - STEP;
                    end

                    // The paddle face is checked before the far wall so a ball grazing it bounces.
                    if (!dx_right_q && bx < STEP12) begin
                        x_d        = '0;
                        dx_right_d = 1'b1;
                    end else if (dx_right_q && (bx + SIZE12 + STEP12 > PADX12) &&
                                 (bx + SIZE12 <= PADX12) && pad_overlap) begin
                        x_d        = X_PAD;
                        dx_right_d = 1'b0;
                        hit_d      = 1'b1;
                    end else if (dx_right_q && (bx + SIZE12 + STEP12 > HMAX12)) begin
                        miss_d  = 1'b1;
                        state_d = MISS;
                    end else begin
                        x_d = dx_right_q ? x_q + STEP : x_q - STEP;
                    end
                end
            end
            MISS: begin
                if (bus.frame_end_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        x_d        = CENTER_X;
                        y_d        = CENTER_Y;
                        dx_right_d = 1'b1;
                        dy_down_d  = ~dy_down_q;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign on_d      = (hc12 >= bx) && (hc12 < bx + SIZE12) &&
                       (vc12 >= by) && (vc12 < by + SIZE12);
    assign playing_d = (state_d == PLAY);

    assign bus.ball_x_o  = x_q;
    assign bus.ball_y_o  = y_q;
    assign bus.ball_on_o = on_q;
    assign bus.hit_o     = hit_q;
    assign bus.miss_o    = miss_q;
    assign bus.playing_o = playing_q;
endmodule
